// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the BCD<->binary conversion blocks.
package bcd_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [NIBBLE_W-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [NIBBLE_W-1:0] BCD_ADJ       = 4'd3;
  localparam logic [NIBBLE_W-1:0] BCD_ADJ_MIN   = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction: after a right shift a decimal digit
// that reads 8 or more subtracts 3 so the carried-in half-ten is folded back.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_digit,
  output logic [NIBBLE_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_MIN) ? (i_digit - BCD_ADJ) : i_digit;

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to binary converter, one reverse double-dabble step per clock.
// Define BCD_INVALID_DIGIT_CHECK_EN to flag operands holding a nibble above 9 on err.
module bcd_to_binary_converter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NIBBLE_W*DIGITS-1:0] bcd_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BIN_W-1:0]           bin_out,
  output logic                       err
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BCD_W + 1);

  if ((2 ** BIN_W) < (10 ** DIGITS)) begin : g_width_check
    $error("BIN_W too narrow for DIGITS decimal digits");
  end

  state_t             r_state;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_step;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [BIN_W-1:0]   r_bin_out;

  logic [2*BCD_W-1:0] w_shift;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_bin_next;
  logic [BIN_W-1:0]   w_bin_res;
  logic               w_last;

  // The whole {bcd,bin} pair moves right as one word; digits are then corrected.
  assign w_shift    = {r_bcd, r_bin} >> 1;
  assign w_bin_next = w_shift[BCD_W-1:0];
  assign w_bin_res  = BIN_W'(w_bin_next);
  assign w_last     = (r_step == CNT_W'(BCD_W - 1));

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (w_shift[BCD_W + gi*NIBBLE_W +: NIBBLE_W]),
      .o_digit (w_bcd_adj[gi*NIBBLE_W +: NIBBLE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bcd       <= '0;
      r_bin       <= '0;
      r_step      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bin_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bcd      <= bcd_in;
            r_bin      <= '0;
            r_step     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd  <= w_bcd_adj;
          r_bin  <= w_bin_next;
          r_step <= r_step + CNT_W'(1);
          if (w_last) begin
            r_bin_out   <= w_bin_res;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef BCD_INVALID_DIGIT_CHECK_EN
  logic [DIGITS-1:0] w_nib_bad;
  logic              r_err_cap;
  logic              r_err;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
    assign w_nib_bad[gi] = (bcd_in[gi*NIBBLE_W +: NIBBLE_W] > BCD_MAX_DIGIT);
  end

  // Flag is taken at capture and only surfaces together with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cap <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) r_err_cap <= |w_nib_bad;
      if (r_state == SHIFT && w_last)  r_err     <= r_err_cap;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bin_out   = r_bin_out;

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Directed bench for bcd_to_binary_converter with a result scoreboard.
module tb_bcd_to_binary_converter;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] bcd_in = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [6:0] bin_out;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] bin;
    logic       err;
    bit         check_bin;
  } exp_t;

  exp_t sb[$];

  bcd_to_binary_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] bin2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic exp_err(input logic [7:0] b);
`ifdef BCD_INVALID_DIGIT_CHECK_EN
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  // Waits for in_ready, then presents b for exactly one accepting edge.
  task automatic send(input logic [7:0] b, input bit push, input bit check_bin, input logic [6:0] bin);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout("accept");
    bcd_in   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (push) begin
      e.bcd = b; e.bin = bin; e.err = exp_err(b); e.check_bin = check_bin;
      sb.push_back(e);
    end
  endtask

  // Called right after send(); measures latency, optionally stalls, then accepts.
  task automatic collect(input int stall);
    int n = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid || n >= 40) break;
      @(posedge clk);
      n++;
    end
    if (!out_valid) begin
      timeout("out_valid");
      return;
    end
    chk("latency", n, 4 * DIGITS);
    if (sb.size() == 0) begin
      timeout("scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    if (stall > 0) begin
      bcd_in   = 8'h42;
      in_valid = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(posedge clk);
        @(negedge clk);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_bin_hold", bin_out, e.bin);
      end
      in_valid = 1'b0;
    end
    chk("out_valid", out_valid, 1);
    chk("in_ready_busy", in_ready, 0);
    if (e.check_bin) chk("bin_out", bin_out, e.bin);
    chk("err", err, e.err);
    $display("txn bcd=%02h bin_out=%0d err=%0b latency=%0d stall=%0d", e.bcd, bin_out, err, n, stall);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(8'h00, 1, 1, 7'd0);  collect(0);
    send(8'h31, 1, 1, 7'd31); collect(0);
    send(8'h99, 1, 1, 7'd99); collect(0);
    send(8'h10, 1, 1, 7'd10); collect(0);
    send(8'h09, 1, 1, 7'd9);  collect(0);

    // Back-pressure with a stray operand offered during the stall.
    out_ready = 1'b0;
    send(8'h64, 1, 1, 7'd64);
    collect(5);
    repeat (12) @(negedge clk);
    chk("no_stray_capture_valid", out_valid, 0);
    chk("no_stray_capture_ready", in_ready, 1);

    for (int v = 0; v < 100; v++) begin
      send(bin2bcd(v), 1, 1, 7'(v));
      collect(0);
    end

    // Reset in the middle of the shift sequence.
    send(8'h77, 0, 0, 7'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_bin_out", bin_out, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h05, 1, 1, 7'd5); collect(0);

    send(8'h3A, 1, 0, 7'd0);  collect(0);
    send(8'h39, 1, 1, 7'd39); collect(0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
